// File: rtl/syn_tle.sv
`default_nettype none
// syn_tle: pipelined signed matrix multiply-accumulate D = A*B + C, with an optional
// dual-lane half-precision mode. Rev 1.0
module syn_tle #(
  parameter int M            = 2,
  parameter int N            = 2,
  parameter int K            = 2,
  parameter int P            = 8,
  parameter int PIPESTAGES   = 2,
  parameter int TREE         = 0,
  parameter int CONFIGURABLE = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic signed [P-1:0]   A_i [M][K],
  input  logic signed [P-1:0]   B_i [K][N],
  input  logic signed [4*P-1:0] C_i [M][N],
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic signed [4*P-1:0] D_o [M][N],
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic                  halvedPrecision
);
  localparam int W = 4 * P;
  localparam int L = 2 * P;
  localparam int H = P / 2;

  // In half mode the two 2P-bit lanes add independently so no carry crosses.
  function automatic logic [W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic half);
    logic [W-1:0] s;
    if (half) begin
      s[L-1:0] = a[L-1:0] + b[L-1:0];
      s[W-1:L] = a[W-1:L] + b[W-1:L];
    end else begin
      s = a + b;
    end
    return s;
  endfunction

  function automatic logic [W-1:0] mul(input logic [P-1:0] a, input logic [P-1:0] b,
                                       input logic half);
    logic [W-1:0] ea, eb;
    logic [L-1:0] al, bl, ah, bh, pl, ph;
    ea = {{(W-P){a[P-1]}}, a};
    eb = {{(W-P){b[P-1]}}, b};
    al = {{(L-H){a[H-1]}}, a[H-1:0]};
    bl = {{(L-H){b[H-1]}}, b[H-1:0]};
    ah = {{(L-H){a[P-1]}}, a[P-1:H]};
    bh = {{(L-H){b[P-1]}}, b[P-1:H]};
    pl = al * bl;
    ph = ah * bh;
    return half ? {ph, pl} : ea * eb;
  endfunction

  logic         half_mode;
  logic [W-1:0] sum_d [M][N];

  assign half_mode = (CONFIGURABLE != 0) && halvedPrecision;

  generate
    if (TREE != 0) begin : g_tree
      always_comb begin
        logic [W-1:0] t [K];
        int           span;
        for (int m = 0; m < M; m++) begin
          for (int n = 0; n < N; n++) begin
            for (int k = 0; k < K; k++) t[k] = mul(A_i[m][k], B_i[k][n], half_mode);
            span = K;
            // Pairwise in-place reduction; an odd leftover passes through to the next level.
            for (int lvl = 0; lvl < $clog2(K); lvl++) begin
              for (int i = 0; i < (K + 1) / 2; i++) begin
                if (2 * i + 1 < span)  t[i] = lane_add(t[2*i], t[2*i+1], half_mode);
                else if (2 * i < span) t[i] = t[2*i];
              end
              span = (span + 1) / 2;
            end
            sum_d[m][n] = lane_add(t[0], C_i[m][n], half_mode);
          end
        end
      end
    end else begin : g_chain
      always_comb begin
        logic [W-1:0] acc;
        for (int m = 0; m < M; m++) begin
          for (int n = 0; n < N; n++) begin
            acc = C_i[m][n];
            for (int k = 0; k < K; k++)
              acc = lane_add(acc, mul(A_i[m][k], B_i[k][n], half_mode), half_mode);
            sum_d[m][n] = acc;
          end
        end
      end
    end
  endgenerate

  logic [W-1:0] stage_d [PIPESTAGES][M][N];
  logic         stage_v [PIPESTAGES];
  logic         en;

  assign en      = !valid_o || ready_i;
  assign ready_o = en;
  assign valid_o = stage_v[PIPESTAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < PIPESTAGES; s++) begin
        stage_v[s] <= 1'b0;
        for (int m = 0; m < M; m++)
          for (int n = 0; n < N; n++) stage_d[s][m][n] <= '0;
      end
    end else if (en) begin
      stage_v[0] <= valid_i;
      for (int m = 0; m < M; m++)
        for (int n = 0; n < N; n++) stage_d[0][m][n] <= sum_d[m][n];
      for (int s = 1; s < PIPESTAGES; s++) begin
        stage_v[s] <= stage_v[s-1];
        for (int m = 0; m < M; m++)
          for (int n = 0; n < N; n++) stage_d[s][m][n] <= stage_d[s-1][m][n];
      end
    end
  end

  always_comb begin
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++) D_o[m][n] = stage_d[PIPESTAGES-1][m][n];
  end

endmodule
`default_nettype wire

// File: tb/tb_syn_tle.sv
`default_nettype none
// tb_syn_tle: directed self-checking bench; one configurable tree instance and one
// fixed-precision chain instance share the same stimulus.
module tb_syn_tle;
  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [7:0]  A [2][2];
  logic signed [7:0]  B [2][2];
  logic signed [31:0] C [2][2];
  logic              valid_in, ready_in, half;
  logic              ready_c, valid_c, ready_f, valid_f;
  logic signed [31:0] D_c [2][2];
  logic signed [31:0] D_f [2][2];
  int                n_cmp = 0;
  int                n_err = 0;

  always #5 clk = ~clk;

  syn_tle #(.M(2), .N(2), .K(2), .P(8), .PIPESTAGES(2), .TREE(1), .CONFIGURABLE(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .A_i(A), .B_i(B), .C_i(C), .valid_i(valid_in),
    .ready_o(ready_c), .D_o(D_c), .valid_o(valid_c), .ready_i(ready_in), .halvedPrecision(half));

  syn_tle #(.M(2), .N(2), .K(2), .P(8), .PIPESTAGES(2), .TREE(0), .CONFIGURABLE(0)) dut_f (
    .clk_i(clk), .rst_ni(rst_n), .A_i(A), .B_i(B), .C_i(C), .valid_i(valid_in),
    .ready_o(ready_f), .D_o(D_f), .valid_o(valid_f), .ready_i(ready_in), .halvedPrecision(half));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [31:0] c,
                       input logic h, input logic v);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        A[i][j] = a;
        B[i][j] = b;
        C[i][j] = c;
      end
    half     = h;
    valid_in = v;
  endtask

  task automatic check_d(input string tag, input logic [31:0] exp_c, input logic [31:0] exp_f);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        check($sformatf("%s_c[%0d][%0d]", tag, i, j), D_c[i][j], exp_c);
        check($sformatf("%s_f[%0d][%0d]", tag, i, j), D_f[i][j], exp_f);
      end
  endtask

  // Send one transfer, confirm nothing emerges after one edge, then the result after two.
  task automatic one_shot(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [31:0] c, input logic h,
                          input logic [31:0] exp_c, input logic [31:0] exp_f);
    drive(a, b, c, h, 1'b1);
    @(negedge clk);
    drive(8'h00, 8'h00, 32'h0, 1'b0, 1'b0);
    check({tag, "_lat1_valid"}, {31'b0, valid_c}, 32'd0);
    @(negedge clk);
    check({tag, "_valid_c"}, {31'b0, valid_c}, 32'd1);
    check({tag, "_valid_f"}, {31'b0, valid_f}, 32'd1);
    check_d(tag, exp_c, exp_f);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got [$];
    int          seen;

    rst_n    = 1'b0;
    ready_in = 1'b1;
    drive(8'h00, 8'h00, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_valid", {31'b0, valid_c}, 32'd0);
    check("rst_ready", {31'b0, ready_c}, 32'd1);
    check_d("rst_d", 32'h0, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    one_shot("full",  8'd1,   8'd2,   32'd3,        1'b0, 32'd7,        32'd7);
    one_shot("half",  8'h11,  8'h11,  32'h11,       1'b1, 32'h0002_0013, 32'd595);
    one_shot("wrap",  8'h80,  8'h80,  32'h7FFFFFFF, 1'b0, 32'h8000_7FFF, 32'h8000_7FFF);
    one_shot("lanes", 8'h88,  8'h88,  32'h7FFF,     1'b1, 32'h0080_807F, 32'h0000_F07F);

    // Mixed-mode back-to-back transfers.
    drive(8'h11, 8'h11, 32'h11, 1'b1, 1'b1);
    @(negedge clk);
    drive(8'd1, 8'd2, 32'd3, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'h00, 8'h00, 32'h0, 1'b0, 1'b0);
    check("mix0_valid", {31'b0, valid_c}, 32'd1);
    check_d("mix0", 32'h0002_0013, 32'd595);
    @(negedge clk);
    check("mix1_valid", {31'b0, valid_c}, 32'd1);
    check_d("mix1", 32'd7, 32'd7);
    @(negedge clk);
    check("mix_drain", {31'b0, valid_c}, 32'd0);

    // Backpressure: four transfers D = 2,4,6,8 with the sink stalled at first.
    ready_in = 1'b0;
    drive(8'd1, 8'd1, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'd2, 8'd1, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'd3, 8'd1, 32'd0, 1'b0, 1'b1);
    check("bp_ready_low", {31'b0, ready_c}, 32'd0);
    check("bp_valid", {31'b0, valid_c}, 32'd1);
    check("bp_d0", D_c[1][1], 32'd2);
    @(negedge clk);
    check("bp_hold", D_c[1][1], 32'd2);
    check("bp_hold_f", D_f[0][1], 32'd2);
    ready_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (valid_c && ready_in) got.push_back(D_c[1][1]);
      if (c == 1)     drive(8'd4, 8'd1, 32'd0, 1'b0, 1'b1);
      else if (c > 1) drive(8'h00, 8'h00, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
    end
    check("bp_count", got.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp_order%0d", i), (i < got.size()) ? got[i] : 32'hDEAD_BEEF,
            32'(2 * (i + 1)));

    // Reset with two transfers in flight.
    drive(8'd5, 8'd1, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'd6, 8'd1, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'h00, 8'h00, 32'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'b0, valid_c}, 32'd0);
    check("mrst_ready", {31'b0, ready_c}, 32'd1);
    check_d("mrst_d", 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (valid_c || valid_f) seen++;
    end
    check("mrst_no_ghost", seen, 32'd0);
    one_shot("post", 8'd3, 8'd3, 32'd1, 1'b0, 32'd19, 32'd19);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
